// File: rtl/keypad_matrix_scanner.sv
// ROWS x COLS keypad scanner: one-hot row drive, debounced press/release,
// single-key qualification and optional auto-repeat, all paced by a scan tick.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// SCAN     | walking the rows, waiting for a single key on the driven row
// PRESS_DB | row frozen, counting stable ticks of the latched key
// HELD     | key debounced and held; auto-repeat timer runs here
// REL_DB   | latched key reads open, counting ticks toward release
module keypad_matrix_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE     = 24,
    parameter int REPEAT_DELAY = 0,
    parameter int REPEAT_RATE  = 8,
    parameter int KW           = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [COLS-1:0] col,
    output logic [ROWS-1:0] rowScan,
    output logic [KW-1:0]   keyCode,
    output logic            keyValid,
    output logic            isRepeat,
    output logic            keyRelease,
    output logic            keyHeld
);

    localparam int TW  = $clog2(SCAN_DIV);
    localparam int RW  = $clog2(ROWS);
    localparam int CW  = $clog2(COLS);
    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam int RPW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

    state_t          state;
    logic [TW-1:0]   div_cnt;
    logic            tick;
    logic [RW-1:0]   row_idx;
    logic [RW-1:0]   row_nxt;
    logic [COLS-1:0] col_lat;
    logic [CW-1:0]   col_idx;
    logic [CW-1:0]   col_idx_c;
    logic [DBW-1:0]  db_cnt;
    logic [DBW-1:0]  db_inc;
    logic [RPW-1:0]  rep_cnt;
    logic [RPW-1:0]  rep_inc;
    logic            valid1;
    logic            lat_bit;
    logic            others;

    function automatic logic [KW-1:0] key_code(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return KW'(int'(r) * COLS + int'(c));
    endfunction

    assign tick = (div_cnt == TW'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_cnt <= '0;
        else       div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    assign valid1  = (col != '0) && ((col & (col - 1'b1)) == '0);
    assign row_nxt = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
    assign lat_bit = col[col_idx];
    assign others  = |(col & ~col_lat);
    assign db_inc  = (db_cnt == DBW'(DEBOUNCE)) ? db_cnt : db_cnt + 1'b1;
    assign rep_inc = (rep_cnt == RPW'(REPEAT_DELAY + REPEAT_RATE)) ? rep_cnt : rep_cnt + 1'b1;

    always_comb begin
        col_idx_c = '0;
        for (int i = 0; i < COLS; i++)
            if (col[i]) col_idx_c = CW'(i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SCAN;
            row_idx    <= '0;
            rowScan    <= ROWS'(1);
            col_lat    <= '0;
            col_idx    <= '0;
            db_cnt     <= '0;
            rep_cnt    <= '0;
            keyCode    <= '0;
            keyValid   <= 1'b0;
            isRepeat   <= 1'b0;
            keyRelease <= 1'b0;
            keyHeld    <= 1'b0;
        end else begin
            keyValid   <= 1'b0;
            isRepeat   <= 1'b0;
            keyRelease <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (valid1) begin
                            col_lat <= col;
                            col_idx <= col_idx_c;
                            db_cnt  <= DBW'(1);
                            if (DEBOUNCE == 1) begin
                                keyValid <= 1'b1;
                                keyHeld  <= 1'b1;
                                keyCode  <= key_code(row_idx, col_idx_c);
                                rep_cnt  <= '0;
                                state    <= HELD;
                            end else begin
                                state <= PRESS_DB;
                            end
                        end else begin
                            row_idx <= row_nxt;
                            rowScan <= ROWS'(1) << row_nxt;
                        end
                    end
                    PRESS_DB: begin
                        if (col == col_lat) begin
                            db_cnt <= db_inc;
                            if (db_inc == DBW'(DEBOUNCE)) begin
                                keyValid <= 1'b1;
                                keyHeld  <= 1'b1;
                                keyCode  <= key_code(row_idx, col_idx);
                                rep_cnt  <= '0;
                                state    <= HELD;
                            end
                        end else begin
                            db_cnt  <= '0;
                            row_idx <= row_nxt;
                            rowScan <= ROWS'(1) << row_nxt;
                            state   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (!lat_bit) begin
                            db_cnt <= DBW'(1);
                            if (DEBOUNCE == 1) begin
                                keyRelease <= 1'b1;
                                keyHeld    <= 1'b0;
                                row_idx    <= row_nxt;
                                rowScan    <= ROWS'(1) << row_nxt;
                                state      <= SCAN;
                            end else begin
                                state <= REL_DB;
                            end
                        end else if (!others && REPEAT_DELAY != 0) begin
                            // Folding back to REPEAT_DELAY keeps the repeat period without letting repCnt grow
                            rep_cnt <= (rep_inc == RPW'(REPEAT_DELAY + REPEAT_RATE)) ? RPW'(REPEAT_DELAY) : rep_inc;
                            if (rep_inc == RPW'(REPEAT_DELAY) || rep_inc == RPW'(REPEAT_DELAY + REPEAT_RATE)) begin
                                keyValid <= 1'b1;
                                isRepeat <= 1'b1;
                            end
                        end
                    end
                    REL_DB: begin
                        if (!lat_bit) begin
                            db_cnt <= db_inc;
                            if (db_inc == DBW'(DEBOUNCE)) begin
                                keyRelease <= 1'b1;
                                keyHeld    <= 1'b0;
                                db_cnt     <= '0;
                                row_idx    <= row_nxt;
                                rowScan    <= ROWS'(1) << row_nxt;
                                state      <= SCAN;
                            end
                        end else begin
                            state <= HELD;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Drives a simulated 4x4 keypad into two scanners (auto-repeat on and off) and
// compares their events against a tick-level behavioural keypad model.
module tb_keypad_matrix_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int SDIV = 4;
    localparam int DEB  = 3;
    localparam int RD   = 5;
    localparam int RR   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col = '0;

    logic [3:0] rowScan, keyCode, rowScan0, keyCode0;
    logic       keyValid, isRepeat, keyRelease, keyHeld;
    logic       keyValid0, isRepeat0, keyRelease0, keyHeld0;

    always #5 clk = ~clk;

    keypad_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE(DEB),
                            .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk(clk), .reset(reset), .col(col), .rowScan(rowScan), .keyCode(keyCode),
        .keyValid(keyValid), .isRepeat(isRepeat), .keyRelease(keyRelease), .keyHeld(keyHeld));

    keypad_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE(DEB),
                            .REPEAT_DELAY(0), .REPEAT_RATE(RR)) dut0 (
        .clk(clk), .reset(reset), .col(col), .rowScan(rowScan0), .keyCode(keyCode0),
        .keyValid(keyValid0), .isRepeat(isRepeat0), .keyRelease(keyRelease0), .keyHeld(keyHeld0));

    typedef struct {
        bit rel;
        bit rep;
        int code;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;

    // Model: row being scanned, key under press debounce, held key, and tick counters
    int m_row, m_cand, m_cnt, m_held, m_rel, m_hold, m_last;
    bit ev_val, ev_rep, ev_rel;
    int ev_code;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_row = 0; m_cand = -1; m_cnt = 0; m_held = -1; m_rel = 0; m_hold = 0; m_last = 0;
    endtask

    task automatic model_step(input logic [3:0] c);
        int ones, idx;
        bit b, other;
        ev_val = 0; ev_rep = 0; ev_rel = 0; ev_code = m_last;
        ones = $countones(c);
        idx = 0;
        for (int i = 0; i < COLS; i++) if (c[i]) idx = i;
        if (m_held < 0) begin
            if (m_cand < 0) begin
                if (ones == 1) begin
                    m_cand = m_row * COLS + idx;
                    m_cnt  = 1;
                end else begin
                    m_row = (m_row + 1) % ROWS;
                end
            end else if (int'(c) == (1 << (m_cand % COLS))) begin
                m_cnt++;
                if (m_cnt == DEB) begin
                    ev_val = 1; ev_code = m_cand; m_last = m_cand;
                    m_held = m_cand; m_cand = -1; m_hold = 0; m_rel = 0;
                end
            end else begin
                m_cand = -1;
                m_row  = (m_row + 1) % ROWS;
            end
        end else begin
            b     = c[m_held % COLS];
            other = (int'(c) & ~(1 << (m_held % COLS))) != 0;
            if (m_rel > 0) begin
                if (!b) begin
                    m_rel++;
                    if (m_rel == DEB) begin
                        ev_rel = 1; ev_code = m_held;
                        m_held = -1; m_rel = 0;
                        m_row = (m_row + 1) % ROWS;
                    end
                end else begin
                    m_rel = 0;
                end
            end else if (!b) begin
                m_rel = 1;
            end else if (!other) begin
                m_hold++;
                if (m_hold >= RD && (m_hold - RD) % RR == 0) begin
                    ev_val = 1; ev_rep = 1; ev_code = m_held;
                end
            end
        end
    endtask

    // One scan period: keypad presents the driven row's keys, the tick edge closes it
    task automatic do_tick(input logic [15:0] keys);
        chk("rowScan", rowScan, 1 << m_row);
        chk("rowScan_norep", rowScan0, 1 << m_row);
        chk("keyHeld", keyHeld, m_held >= 0);
        chk("keyHeld_norep", keyHeld0, m_held >= 0);
        col = keys[m_row*COLS +: COLS];
        model_step(col);
        if (ev_val || ev_rel) sb.push_back('{ev_rel, ev_rep, ev_code});
        repeat (SDIV) @(posedge clk);
        #1;
        chk("keyValid_norep", keyValid0, ev_val && !ev_rep);
        chk("keyRelease_norep", keyRelease0, ev_rel);
        chk("isRepeat_norep", isRepeat0, 0);
        if ((ev_val && !ev_rep) || ev_rel) chk("keyCode_norep", keyCode0, ev_code);
    endtask

    task automatic hold(input logic [15:0] keys, input int n);
        for (int t = 0; t < n; t++) do_tick(keys);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!reset && (keyValid || keyRelease)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", int'({keyValid, keyRelease}), 0);
            end else begin
                e = sb.pop_front();
                chk("ev_keyValid", keyValid, !e.rel);
                chk("ev_keyRelease", keyRelease, e.rel);
                chk("ev_isRepeat", isRepeat, e.rep);
                chk("ev_keyCode", keyCode, e.code);
                chk("ev_keyHeld", keyHeld, !e.rel);
            end
        end
    end

    localparam logic [15:0] K9 = 16'h0200;

    initial begin
        int kind, dur, k, k2;
        logic [15:0] m, extra;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_rowScan", rowScan, 1);
        chk("reset_outputs", int'({keyCode, keyValid, isRepeat, keyRelease, keyHeld}), 0);
        reset = 1'b0;

        hold(16'h0000, 8);                       // idle scan
        hold(K9, 10);                            // row 2 / col 1 press, one repeat
        chk("first_press_code", keyCode0, 9);
        hold(16'h0000, 2);                       // short gap, no release
        hold(K9, 3);
        hold(16'h0000, 4);                       // full release
        for (int t = 0; t < 8; t++) do_tick((t % 2) ? 16'h0000 : K9);   // bounce
        hold(16'h0000, 4);
        hold(16'h0300, 6);                       // two keys in one row
        hold(K9, 8);
        hold(16'h0600, 4);                       // second key while held
        hold(K9, 4);
        hold(16'h0000, 5);

        hold(16'h0020, 16);                      // key 5 held, then reset mid-hold
        chk("held_before_reset", keyHeld, 1);
        chk("code_before_reset", keyCode, 5);
        reset = 1'b1;
        #1;
        chk("midreset_rowScan", rowScan, 1);
        chk("midreset_keyCode", keyCode, 0);
        chk("midreset_flags", int'({keyValid, isRepeat, keyRelease, keyHeld}), 0);
        sb.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        hold(16'h0000, 3);

        for (int p = 0; p < 80; p++) begin
            kind  = $urandom_range(0, 5);
            dur   = $urandom_range(1, 14);
            k     = $urandom_range(0, 15);
            k2    = $urandom_range(0, 15);
            m     = 16'(1) << k;
            extra = 16'(1) << ((k / 4) * 4 + (k + 2) % 4);
            if (kind == 0) m = '0;
            if (kind == 2) m = m | (16'(1) << ((k / 4) * 4 + (k + 1) % 4));
            if (kind == 3) m = m | (16'(1) << k2);
            for (int t = 0; t < dur; t++) begin
                if (kind == 4)                    do_tick((t % 2) ? 16'h0000 : m);
                else if (kind == 5 && t >= dur/2) do_tick(m | extra);
                else                              do_tick(m);
            end
        end

        repeat (8) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Parametrised matrix-keypad scanner with debounced press detection, debounced release detection, multi-key rejection and optional auto-repeat. It drives the keypad rows one-hot, samples the already-synchronized column inputs, and emits a key code with one-cycle event strobes. It sits between the column synchronizer and the key decode/display logic. It replaces the fixed 4x4 scanner with a generic ROWS x COLS version.

## Interface
Parameters:
- ROWS, 4, number of driven rows (≥2)
- COLS, 4, number of sensed columns (≥2)
- SCAN_DIV, 100000, clk cycles per scan tick (≥2)
- DEBOUNCE, 24, consecutive stable ticks required for press and for release (≥1)
- REPEAT_DELAY, 0, ticks from first keyValid to first repeat; 0 disables auto-repeat
- REPEAT_RATE, 8, ticks between subsequent repeats (≥1)
- KW, $clog2(ROWS*COLS), key code width (derived)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- col  in  COLS  synchronized column sense, active-high
- rowScan  out  ROWS  one-hot row drive
- keyCode  out  KW  row*COLS + column index of the current/last key
- keyValid  out  1  one-clk strobe: debounced press or repeat
- isRepeat  out  1  qualifies keyValid; 1 = auto-repeat event
- keyRelease  out  1  one-clk strobe: debounced release of keyCode
- keyHeld  out  1  level; a debounced key is currently held

## Operation
- Tick generator: counter 0..SCAN_DIV-1. tick is high for one clk when counter == SCAN_DIV-1, then the counter wraps to 0. All FSM and debounce activity advances only on tick.
- valid1: col is nonzero and exactly one bit is set.
- States: SCAN, PRESS_DB, HELD, REL_DB.
- SCAN, on tick:
  - If valid1: latch row and column index, set dbCnt=1, go PRESS_DB. If DEBOUNCE==1, emit keyValid immediately and go HELD.
  - Else: advance the row (ROWS-1 wraps to 0).
- PRESS_DB, on tick. The row stays frozen.
  - col equals the latched one-hot: dbCnt++. When dbCnt reaches DEBOUNCE: emit keyValid (isRepeat=0), set keyHeld=1, clear repCnt, go HELD.
  - Any other col value, including 0 or multi-key: dbCnt=0, advance the row, go SCAN. No strobe.
- HELD, on tick:
  - Latched bit is 0: dbCnt=1, go REL_DB.
  - Latched bit is 1 but other bits are also set (multi-key): stay in HELD. repCnt is frozen.
  - Otherwise, with REPEAT_DELAY≠0: repCnt++. At REPEAT_DELAY, then every REPEAT_RATE ticks after it, emit keyValid with isRepeat=1.
- REL_DB, on tick:
  - Latched bit is 0: dbCnt++. When dbCnt reaches DEBOUNCE: emit keyRelease, clear keyHeld, advance the row, go SCAN.
  - Latched bit is 1: return to HELD. repCnt resumes from its held value.
- keyCode updates only when a press-debounce completes. It holds its value through repeats and release, until the next debounced press.
- Simultaneous events: a release strobe and a press strobe can never fall on the same tick, because a new press always needs ≥1 tick in SCAN first.
- Counters saturate. No wrap-around is permitted in dbCnt or repCnt.

## Timing
- Reset values (asynchronous, immediate):
  - rowScan = one-hot row 0
  - keyCode = 0
  - keyValid, isRepeat, keyRelease, keyHeld = 0
  - tick counter = 0, state = SCAN, dbCnt = repCnt = 0
- The first tick occurs SCAN_DIV clk cycles after reset deasserts.
- All outputs are registered. The strobes (keyValid, keyRelease) are high for exactly the one clk cycle after the tick edge that completes the condition. isRepeat is valid in that same cycle and is 0 otherwise.
- keyHeld rises in the same cycle as the first keyValid and falls in the same cycle as keyRelease.
- rowScan changes in the cycle after a tick. It is constant while in PRESS_DB, HELD and REL_DB.
- Press latency from a stable col to keyValid: DEBOUNCE ticks, counted from the first tick that samples the key on its row.
- Reset mid-operation: in-progress debounce is discarded and no release strobe is issued.

## Test plan
Parameters for all tests: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3, REPEAT_DELAY=0 unless stated.
- Idle scan, col=0: rowScan cycles 0001→0010→0100→1000→0001, advancing every 4 clk. No strobes fire.
- Row 2 / col bit 1 held steady: exactly one keyValid with keyCode=9 and isRepeat=0, on the 3rd tick after rowScan=0100 first samples it. keyHeld=1 afterwards.
- Bounce: col toggles 0010/0000 every tick during PRESS_DB. No keyValid. Scanning resumes at row 3.
- Release: from HELD, col=0 for 3 ticks gives one keyRelease with keyCode=9 and keyHeld falling. A 2-tick gap followed by a re-press gives no release and no new keyValid.
- Multi-key: col=0011 in SCAN gives no press. Adding a second key while HELD gives no strobe and keeps keyHeld=1.
- Auto-repeat with REPEAT_DELAY=5, REPEAT_RATE=2: after the first keyValid, repeat strobes with isRepeat=1 fire at ticks 5, 7, 9 of a continuous hold. Asserting reset mid-hold clears all outputs immediately.
